// File: rtl/sort_cmd_driver.sv
// SORT command initiator: replays staged values as mode/push/pop/sort
// commands, then captures and self-checks the 10-word result burst.
module sort_cmd_driver #(
   parameter int DEPTH   = 10,
   parameter int TIMEOUT = 32
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_valid,
   input  logic [4:0] ld_data,
   input  logic       start,
   input  logic       cfg_mode,
   input  logic [3:0] cfg_len,
   input  logic [3:0] cfg_pops,
   output logic       in_valid1,
   output logic       in_valid2,
   output logic       mode,
   output logic [1:0] op,
   output logic [4:0] in,
   input  logic       out_valid,
   input  logic [4:0] out,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic       err_timeout,
   output logic [8:0] cap_sum
);

   localparam int CW = $clog2(TIMEOUT) + 1;

   typedef enum logic [3:0] {
      S_IDLE, S_MODE, S_GAP, S_PUSH, S_POP,
      S_SORT, S_WAIT, S_CAPT, S_DONE
   } state_t;

   state_t state, state_d;
   logic [CW-1:0] cnt, cnt_d;

   logic [4:0] stage [DEPTH];
   logic [3:0] ld_ptr;
   logic       mode_r;
   logic [3:0] len_r, pops_r;
   logic [3:0] len_eff, pops_eff;
   logic [3:0] sidx;
   logic [8:0] exp_sum, acc;
   logic [4:0] prev;
   logic       bad, tmo;

   logic       iv1_d, iv2_d, mode_d;
   logic [1:0] op_d;
   logic [4:0] in_d;

   assign len_eff  = (cfg_len > 4'(DEPTH)) ? 4'(DEPTH) : cfg_len;
   assign pops_eff = (cfg_pops > len_eff) ? len_eff : cfg_pops;
   assign sidx     = len_r - 4'd1 - cnt[3:0];
   assign busy     = (state != S_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_IDLE;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      unique case (state)
         S_IDLE: if (start) state_d = S_MODE;
         S_MODE: state_d = S_GAP;
         S_GAP: begin
            cnt_d   = '0;
            state_d = (len_r != 4'd0) ? S_PUSH : S_SORT;
         end
         S_PUSH: begin
            if (cnt[3:0] == len_r - 4'd1) begin
               cnt_d   = '0;
               state_d = (pops_r != 4'd0) ? S_POP : S_SORT;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_POP: begin
            if (cnt[3:0] == pops_r - 4'd1) state_d = S_SORT;
            else cnt_d = cnt + 1'b1;
         end
         S_SORT: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (out_valid) begin
               cnt_d   = CW'(1);
               state_d = S_CAPT;
            end else if (cnt == CW'(TIMEOUT - 1)) begin
               state_d = S_DONE;
            end else begin
               cnt_d = cnt + 1'b1;
            end
         end
         S_CAPT: begin
            if (!out_valid || cnt == CW'(DEPTH - 1)) state_d = S_DONE;
            else cnt_d = cnt + 1'b1;
         end
         S_DONE: state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // SORT-side values are derived from the next state so they register
      // exactly in the cycle the new state is occupied.
      iv1_d  = (state_d == S_PUSH) || (state_d == S_POP) ||
               (state_d == S_SORT);
      iv2_d  = (state_d == S_MODE);
      mode_d = iv2_d & cfg_mode;
      op_d   = 2'd0;
      in_d   = 5'd0;
      if (state_d == S_PUSH) begin
         op_d = 2'd1;
         in_d = stage[cnt_d[3:0]];
      end
      if (state_d == S_SORT) op_d = 2'd2;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_valid1 <= 1'b0;
         in_valid2 <= 1'b0;
         mode      <= 1'b0;
         op        <= 2'd0;
         in        <= 5'd0;
         done      <= 1'b0;
      end else begin
         in_valid1 <= iv1_d;
         in_valid2 <= iv2_d;
         mode      <= mode_d;
         op        <= op_d;
         in        <= in_d;
         done      <= (state == S_DONE);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) stage[i] <= 5'd0;
         ld_ptr <= 4'd0;
      end else if (state == S_IDLE && ld_valid) begin
         stage[ld_ptr] <= ld_data;
         ld_ptr <= (ld_ptr == 4'(DEPTH - 1)) ? 4'd0 : ld_ptr + 4'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode_r      <= 1'b0;
         len_r       <= 4'd0;
         pops_r      <= 4'd0;
         exp_sum     <= 9'd0;
         acc         <= 9'd0;
         prev        <= 5'd0;
         bad         <= 1'b0;
         tmo         <= 1'b0;
         pass        <= 1'b0;
         err_timeout <= 1'b0;
         cap_sum     <= 9'd0;
      end else begin
         unique case (state)
            S_IDLE: if (start) begin
               mode_r      <= cfg_mode;
               len_r       <= len_eff;
               pops_r      <= pops_eff;
               exp_sum     <= 9'd0;
               acc         <= 9'd0;
               prev        <= 5'd0;
               bad         <= 1'b0;
               tmo         <= 1'b0;
               pass        <= 1'b0;
               err_timeout <= 1'b0;
               cap_sum     <= 9'd0;
            end
            S_PUSH: exp_sum <= exp_sum + 9'(stage[cnt[3:0]]);
            S_POP: begin
               if (mode_r) exp_sum <= exp_sum - 9'(stage[cnt[3:0]]);
               else        exp_sum <= exp_sum - 9'(stage[sidx]);
            end
            S_WAIT: begin
               if (out_valid) begin
                  prev <= out;
                  acc  <= acc + 9'(out);
               end else if (cnt == CW'(TIMEOUT - 1)) begin
                  tmo <= 1'b1;
               end
            end
            S_CAPT: begin
               if (out_valid) begin
                  if (out > prev) bad <= 1'b1;
                  prev <= out;
                  acc  <= acc + 9'(out);
               end else begin
                  bad <= 1'b1;
               end
            end
            S_DONE: begin
               pass        <= !bad && !tmo && (acc == exp_sum);
               err_timeout <= tmo;
               cap_sum     <= acc;
            end
            default: ;
         endcase
      end
   end

endmodule
